// File: rtl/fifo_uart_tx.sv
// Pulls bytes one at a time from the shift-register FIFO read port and sends each one
// on txd as an async serial frame: start, 8 data bits LSB first, optional parity, stop bit(s).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty_n,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_INV   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          fifo_rd_q, txd_q, busy_q, done_q;
  logic          txd_d, bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  // Next-state logic; idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (en && fifo_empty_n) state_d = FETCH;
      end
      FETCH: begin
        cnt_d   = '0;
        state_d = LATCH;
      end
      LATCH: begin
        cnt_d   = '0;
        shift_d = fifo_data;
        par_d   = (^fifo_data) ^ PAR_INV;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line level is decoded from the state being entered so txd is registered.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      fifo_rd_q <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      fifo_rd_q <= (state_d == FETCH);
      txd_q     <= txd_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == STOP) && (cnt_d == BIT_LAST) && (idx_d == STOP_LAST);
    end
  end

  assign fifo_rd = fifo_rd_q;
  assign txd     = txd_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO read-port model and serial receiver feed a byte scoreboard;
// waveform timing is checked against segment tables, corner cases by hand-written sequences.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       fifo_empty_n = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd, txd, busy, tx_done;

  // Two parity variants driven from a fixed 0xA5 source.
  logic       pe_en = 1'b0;
  logic       par_avail = 1'b1;
  logic [7:0] par_data = 8'hA5;
  logic       pe_rd, pe_txd, pe_busy, pe_done;
  logic       po_rd, po_txd, po_busy, po_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rd_total = 0;
  int done_total = 0;

  logic [7:0] fifo_mem[$];
  logic [7:0] exp_q[$];
  int         gaps[$];
  bit         g_arm = 1'b0;
  int         g_cnt = 0;

  logic tr_txd  [3][64];
  logic tr_rd   [3][64];
  logic tr_busy [3][64];
  logic tr_done [3][64];

  typedef struct {
    int   sel;
    int   first;
    int   last;
    logic txd;
    logic rd;
    logic busy;
    logic done;
  } seg_t;
  seg_t segs[$];

  fifo_uart_tx #(.CLKS_PER_BIT(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty_n(fifo_empty_n), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .clk(clk), .rst(rst), .en(pe_en), .fifo_empty_n(par_avail), .fifo_data(par_data),
    .fifo_rd(pe_rd), .txd(pe_txd), .busy(pe_busy), .tx_done(pe_done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_po (
    .clk(clk), .rst(rst), .en(pe_en), .fifo_empty_n(par_avail), .fifo_data(par_data),
    .fifo_rd(po_rd), .txd(po_txd), .busy(po_busy), .tx_done(po_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- FIFO read-port model ----------------
  always @(posedge clk) begin
    if (fifo_rd) begin
      check("fifo_underflow", int'(fifo_mem.size() != 0), 1);
      if (fifo_mem.size() != 0) fifo_data <= fifo_mem.pop_front();
    end
  end

  always @(negedge clk) fifo_empty_n = (fifo_mem.size() != 0);

  // ---------------- serial receiver / scoreboard ----------------
  bit         m_act = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_sh = 8'h00;

  always @(negedge clk) begin
    rd_total   += int'(fifo_rd);
    done_total += int'(tx_done);
    if (rst) g_arm = 1'b0;
    else if (tx_done) begin
      g_arm = 1'b1;
      g_cnt = 0;
    end else if (g_arm) begin
      if (txd) g_cnt++;
      else begin
        gaps.push_back(g_cnt);
        g_arm = 1'b0;
      end
    end
    if (rst) m_act = 1'b0;
    else if (!m_act) begin
      if (!txd) begin
        m_act = 1'b1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 2 && txd) m_act = 1'b0;
      else if (m_cnt >= 6 && m_cnt <= 34 && ((m_cnt - 6) % 4) == 0) m_sh = {txd, m_sh[7:1]};
      else if (m_cnt == 38) begin
        check("rx_stop", int'(txd), 1);
        if (exp_q.size() == 0) check("rx_unexpected_byte", int'(m_sh), -1);
        else check("rx_byte", int'(m_sh), int'(exp_q.pop_front()));
        m_act = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(logic [7:0] b);
    fifo_mem.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(int target, int budget, string name);
    int n = 0;
    while (done_total < target && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_done_seen"}, int'(done_total >= target), 1);
  endtask

  task automatic wait_rd(int budget, string name);
    int n = 0;
    while (!fifo_rd && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_rd_seen"}, int'(fifo_rd), 1);
  endtask

  task automatic record(int n);
    for (int c = 0; c < n; c++) begin
      tr_txd[0][c] = txd;    tr_rd[0][c] = fifo_rd; tr_busy[0][c] = busy;    tr_done[0][c] = tx_done;
      tr_txd[1][c] = pe_txd; tr_rd[1][c] = pe_rd;   tr_busy[1][c] = pe_busy; tr_done[1][c] = pe_done;
      tr_txd[2][c] = po_txd; tr_rd[2][c] = po_rd;   tr_busy[2][c] = po_busy; tr_done[2][c] = po_done;
      tick(1);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] a5 = 8'hA5;
    int rd0, d0, bad_rd, bad_txd, bad_busy;

    // Timing tables: sel 0 = default frame, 1 = even parity, 2 = odd parity + 2 stop bits.
    for (int s = 0; s < 3; s++) begin
      segs.push_back('{s, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0});
      segs.push_back('{s, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0});
      segs.push_back('{s, 2, 5, 1'b0, 1'b0, 1'b1, 1'b0});
      for (int k = 0; k < 8; k++) segs.push_back('{s, 6 + 4 * k, 9 + 4 * k, a5[k], 1'b0, 1'b1, 1'b0});
    end
    segs.push_back('{0, 38, 40, 1'b1, 1'b0, 1'b1, 1'b0});
    segs.push_back('{0, 41, 41, 1'b1, 1'b0, 1'b1, 1'b1});
    segs.push_back('{0, 42, 51, 1'b1, 1'b0, 1'b0, 1'b0});
    segs.push_back('{1, 38, 41, 1'b0, 1'b0, 1'b1, 1'b0});
    segs.push_back('{1, 42, 44, 1'b1, 1'b0, 1'b1, 1'b0});
    segs.push_back('{1, 45, 45, 1'b1, 1'b0, 1'b1, 1'b1});
    segs.push_back('{1, 46, 51, 1'b1, 1'b0, 1'b0, 1'b0});
    segs.push_back('{2, 38, 48, 1'b1, 1'b0, 1'b1, 1'b0});
    segs.push_back('{2, 49, 49, 1'b1, 1'b0, 1'b1, 1'b1});
    segs.push_back('{2, 50, 51, 1'b1, 1'b0, 1'b0, 1'b0});

    // Reset state
    tick(3);
    check("rst_txd", int'(txd), 1);
    check("rst_fifo_rd", int'(fifo_rd), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_done", int'(tx_done), 0);
    check("rst_pe_txd", int'(pe_txd), 1);
    @(negedge clk);
    rst = 1'b0;

    // Single byte 0xA5 on all three instances, traced cycle by cycle from the RD pulse
    push_byte(8'hA5);
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    pe_en = 1'b1;
    tick(1);
    pe_en = 1'b0;
    record(52);
    for (int i = 0; i < segs.size(); i++) begin
      int bad_c = -1;
      logic [3:0] got = 4'h0;
      logic [3:0] want;
      want = {segs[i].txd, segs[i].rd, segs[i].busy, segs[i].done};
      for (int c = segs[i].first; c <= segs[i].last; c++) begin
        logic [3:0] g;
        g = {tr_txd[segs[i].sel][c], tr_rd[segs[i].sel][c], tr_busy[segs[i].sel][c], tr_done[segs[i].sel][c]};
        if (g != want && bad_c < 0) begin
          bad_c = c;
          got = g;
        end
      end
      if (bad_c < 0) got = want;
      check($sformatf("seg%0d_dut%0d_t%0d_{txd,rd,busy,done}", i, segs[i].sel, bad_c), int'(got), int'(want));
    end

    // Back-to-back frames from a preloaded FIFO
    g_arm = 1'b0;
    gaps.delete();
    rd0 = rd_total;
    d0 = done_total;
    push_byte(8'h01);
    push_byte(8'h80);
    push_byte(8'hFF);
    wait_done(d0 + 3, 400, "b2b");
    tick(20);
    check("b2b_rd_pulses", rd_total - rd0, 3);
    check("b2b_done_pulses", done_total - d0, 3);
    check("b2b_gap_count", gaps.size(), 2);
    for (int i = 0; i < 2; i++) check($sformatf("b2b_gap%0d", i), (i < gaps.size()) ? gaps[i] : -1, 3);
    check("b2b_exp_drained", exp_q.size(), 0);
    check("b2b_fifo_empty", fifo_mem.size(), 0);

    // Empty FIFO with en high
    bad_rd = 0;
    bad_txd = 0;
    bad_busy = 0;
    for (int c = 0; c < 100; c++) begin
      bad_rd   += int'(fifo_rd != 1'b0);
      bad_txd  += int'(txd != 1'b1);
      bad_busy += int'(busy != 1'b0);
      tick(1);
    end
    check("empty_rd_cycles", bad_rd, 0);
    check("empty_txd_low_cycles", bad_txd, 0);
    check("empty_busy_cycles", bad_busy, 0);

    // en dropped during data bit 3
    en = 1'b0;
    push_byte(8'h3C);
    push_byte(8'h55);
    rd0 = rd_total;
    d0 = done_total;
    @(negedge clk);
    en = 1'b1;
    wait_rd(10, "en_drop");
    tick(18);
    check("en_drop_bit3_txd", int'(txd), 1);
    en = 1'b0;
    wait_done(d0 + 1, 100, "en_drop");
    tick(30);
    check("en_drop_no_second_rd", rd_total - rd0, 1);
    check("en_drop_idle_busy", int'(busy), 0);
    check("en_drop_fifo_holds", fifo_mem.size(), 1);
    en = 1'b1;
    wait_done(d0 + 2, 100, "en_resume");
    check("en_resume_rd", rd_total - rd0, 2);

    // Reset during data bit 5: in-flight byte is dropped
    tick(2);
    push_byte(8'h96);
    push_byte(8'h42);
    d0 = done_total;
    wait_rd(10, "rst_mid");
    tick(27);
    rst = 1'b1;
    tick(1);
    check("rst_mid_txd", int'(txd), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_fifo_rd", int'(fifo_rd), 0);
    void'(exp_q.pop_front());
    rst = 1'b0;
    tick(1);
    check("rst_release_rd_next", int'(fifo_rd), 1);
    wait_done(d0 + 1, 100, "rst_release");
    tick(10);
    check("final_exp_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
